// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: operand width, controller state encoding, counter width.
package rsa_pkg;

   localparam int RSA_W     = 256;
   localparam int RSA_CNT_W = $clog2(RSA_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } rsa_state_t;

endpackage

// File: rtl/rsa_mod_product_if.sv
// Start/finish handshake bundle between an RSA operand source and the modular product stage.
interface rsa_mod_product_if
   import rsa_pkg::*;
#(
   parameter int W = RSA_W
);

   logic         start;
   logic [W-1:0] N;
   logic [W-1:0] a;
   logic [W:0]   b;
   logic [W-1:0] m;
   logic         busy;
   logic         finish;

   modport master (
      output start, N, a, b,
      input  m, busy, finish
   );

   modport slave (
      input  start, N, a, b,
      output m, busy, finish
   );

endinterface

// File: rtl/rsa_mod_add.sv
// Combinational (x + y) mod n for x, y < n: one W+1-bit add, then a conditional subtract of n.
module rsa_mod_add
   import rsa_pkg::*;
#(
   parameter int W = RSA_W
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] n,
   output logic [W-1:0] r
);

   logic [W:0] s;
   logic       ge;

   assign s  = {1'b0, x} + {1'b0, y};
   assign ge = s[W] | (s[W-1:0] >= n);
   // s - n < n < 2^W, so the subtraction is exact when done modulo 2^W.
   assign r  = ge ? (s[W-1:0] - n) : s[W-1:0];

endmodule

// File: rtl/rsa_mod_product.sv
// m = (a * b) mod N by LSB-first shift-and-add, one multiplier bit per cycle (W+1 cycles).
// finish pulses one cycle after the last step; start is only looked at in IDLE.
module rsa_mod_product
   import rsa_pkg::*;
#(
   parameter int W = RSA_W
) (
   input  logic               clk,
   input  logic               rst,
   rsa_mod_product_if.slave   io
);

   localparam int CW = $clog2(W + 1);

   rsa_state_t   state;
   logic [W-1:0] n_l;
   logic [W:0]   b_l;
   logic [W-1:0] t;
   logic [W-1:0] m_r;
   logic [W-1:0] m_add;
   logic [W-1:0] t_dbl;
   logic [CW-1:0] cnt;
   logic         busy_r;
   logic         fin_r;

   rsa_mod_add #(.W(W)) u_add_mt (
      .x (m_r),
      .y (t),
      .n (n_l),
      .r (m_add)
   );

   rsa_mod_add #(.W(W)) u_add_tt (
      .x (t),
      .y (t),
      .n (n_l),
      .r (t_dbl)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         m_r    <= '0;
         t      <= '0;
         n_l    <= '0;
         b_l    <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         fin_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               fin_r <= 1'b0;
               if (io.start) begin
                  n_l    <= io.N;
                  b_l    <= io.b;
                  t      <= io.a;
                  m_r    <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               // t tracks a * 2^cnt mod N; accumulate it wherever the multiplier bit is set.
               if (b_l[cnt]) m_r <= m_add;
               t <= t_dbl;
               if (cnt == CW'(W)) begin
                  busy_r <= 1'b0;
                  fin_r  <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               fin_r <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               fin_r  <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign io.m      = m_r;
   assign io.busy   = busy_r;
   assign io.finish = fin_r;

endmodule
